// File: rtl/registro_solicitudes.sv
// rtl/registro_solicitudes.sv - debounced elevator button front end with pending-request latches
module registro_solicitudes #(
  parameter int PISOS      = 4,
  parameter int DEB_CICLOS = 4,
  parameter int CW         = $clog2(3*PISOS-1),
  parameter int FW         = $clog2(PISOS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PISOS-1:0] cab,
  input  logic [PISOS-1:0] sube,
  input  logic [PISOS-1:0] baja,
  input  logic             atendido,
  input  logic [FW-1:0]    piso_atendido,
  output logic [PISOS-1:0] pend_cab,
  output logic [PISOS-1:0] pend_sube,
  output logic [PISOS-1:0] pend_baja,
  output logic [CW-1:0]    boton_pres,
  output logic             nuevo
);
  // Button vector layout: [PISOS-1:0] cab, [2*PISOS-1:PISOS] up, [3*PISOS-1:2*PISOS] down
  localparam int N  = 3*PISOS;
  localparam int DW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
  localparam logic [DW-1:0] CNT_FIN = DW'(DEB_CICLOS-1);

  logic [N-1:0]  mask, raw, s1, s2, filt, filt_d, flip, clr, pend, pend_nxt;
  logic [DW-1:0] cnt [N];
  logic [CW-1:0] code_min;

  // Button code: cab k -> k, up k -> PISOS+2k-1, down k -> PISOS+2k-2 (k one-based)
  function automatic int code_of(input int i);
    if (i < PISOS)        return i + 1;
    else if (i < 2*PISOS) return PISOS + 2*(i - PISOS) + 1;
    else                  return PISOS + 2*(i - 2*PISOS);
  endfunction

  // Top-floor up and ground-floor down do not exist; mask them so they stay filtered low
  always_comb begin
    mask            = '1;
    mask[2*PISOS-1] = 1'b0;
    mask[2*PISOS]   = 1'b0;
  end

  assign raw = {baja, sube, cab} & mask;

  // Two-flop synchroniser for every button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // A filtered bit flips on the DEB_CICLOS-th consecutive cycle of disagreement
  always_comb begin
    flip = '0;
    for (int i = 0; i < N; i++)
      flip[i] = (s2[i] != filt[i]) && (cnt[i] == CNT_FIN);
  end

  // Debounce counters, filtered values and their one-cycle delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt   <= '0;
      filt_d <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      filt   <= filt ^ flip;
      filt_d <= filt;
      for (int i = 0; i < N; i++) begin
        if ((s2[i] == filt[i]) || flip[i]) cnt[i] <= '0;
        else                               cnt[i] <= cnt[i] + DW'(1);
      end
    end
  end

  // Served-floor clear mask; out-of-range floor numbers match nothing, and clear beats set
  always_comb begin
    clr = '0;
    for (int f = 0; f < PISOS; f++) begin
      if (atendido && (piso_atendido == FW'(f))) begin
        clr[f]         = 1'b1;
        clr[PISOS+f]   = 1'b1;
        clr[2*PISOS+f] = 1'b1;
      end
    end
    pend_nxt = (pend | (filt & ~filt_d)) & ~clr;
  end

  // Lowest code among the currently held (filtered) buttons, 0 when none
  always_comb begin
    code_min = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (filt[i] && ((code_min == '0) || (CW'(code_of(i)) < code_min)))
        code_min = CW'(code_of(i));
    end
  end

  // Registered outputs: pending latches, new-request pulse and held-button code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      nuevo      <= 1'b0;
      boton_pres <= '0;
    end else begin
      pend       <= pend_nxt;
      nuevo      <= |(pend_nxt & ~pend);
      boton_pres <= code_min;
    end
  end

  assign pend_cab  = pend[PISOS-1:0];
  assign pend_sube = pend[2*PISOS-1:PISOS];
  assign pend_baja = pend[3*PISOS-1:2*PISOS];
endmodule

// File: tb/tb_registro_solicitudes.sv
// tb/tb_registro_solicitudes.sv - directed and randomized check of registro_solicitudes against a reference model
module tb_registro_solicitudes;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cab, sube, baja;
  logic       atendido;
  logic [2:0] piso;

  logic [3:0] a_cab, a_sube, a_baja, a_code;
  logic       a_nuevo;
  logic [7:0] b_cab, b_sube, b_baja;
  logic [4:0] b_code;
  logic       b_nuevo;
  logic [4:0] c_cab, c_sube, c_baja;
  logic [3:0] c_code;
  logic       c_nuevo;

  registro_solicitudes #(.PISOS(4), .DEB_CICLOS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .cab(cab[3:0]), .sube(sube[3:0]), .baja(baja[3:0]),
    .atendido(atendido), .piso_atendido(piso[1:0]),
    .pend_cab(a_cab), .pend_sube(a_sube), .pend_baja(a_baja), .boton_pres(a_code), .nuevo(a_nuevo));

  registro_solicitudes #(.PISOS(8), .DEB_CICLOS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .cab(cab), .sube(sube), .baja(baja),
    .atendido(atendido), .piso_atendido(piso),
    .pend_cab(b_cab), .pend_sube(b_sube), .pend_baja(b_baja), .boton_pres(b_code), .nuevo(b_nuevo));

  registro_solicitudes #(.PISOS(5), .DEB_CICLOS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .cab(cab[4:0]), .sube(sube[4:0]), .baja(baja[4:0]),
    .atendido(atendido), .piso_atendido(piso),
    .pend_cab(c_cab), .pend_sube(c_sube), .pend_baja(c_baja), .boton_pres(c_code), .nuevo(c_nuevo));

  always #5 clk = ~clk;

  int    np [3]    = '{4, 8, 5};
  int    nd [3]    = '{4, 1, 2};
  int    nfw[3]    = '{2, 3, 3};
  string names[3]  = '{"A", "B", "C"};

  bit m_d1[3][24], m_d2[3][24], m_filt[3][24], m_rose[3][24], m_pend[3][24];
  int m_run[3][24];
  int m_code[3];
  bit m_nuevo[3];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit raw_bit(input int n, input int i);
    int p = np[n];
    if (i < p) return cab[i];
    if (i < 2*p) return (i - p == p - 1) ? 1'b0 : sube[i-p];
    return (i == 2*p) ? 1'b0 : baja[i-2*p];
  endfunction

  // Which button owns a given code: cab 1..P, then alternating down/up by floor
  function automatic int idx_of_code(input int p, input int c);
    int d;
    if (c <= p) return c - 1;
    d = c - p;
    if (d % 2 == 1) return p + (d + 1) / 2 - 1;
    return 2*p + (d + 2) / 2 - 1;
  endfunction

  task automatic model_reset(input int n);
    for (int i = 0; i < 24; i++) begin
      m_d1[n][i] = 0; m_d2[n][i] = 0; m_filt[n][i] = 0;
      m_rose[n][i] = 0; m_pend[n][i] = 0; m_run[n][i] = 0;
    end
    m_code[n]  = 0;
    m_nuevo[n] = 0;
  endtask

  task automatic model_step(input int n);
    int p, pf;
    bit nb;
    p  = np[n];
    pf = int'(piso) % (1 << nfw[n]);
    m_code[n] = 0;
    for (int c = 3*p-2; c >= 1; c--)
      if (m_filt[n][idx_of_code(p, c)]) m_code[n] = c;
    m_nuevo[n] = 0;
    for (int i = 0; i < 3*p; i++) begin
      nb = (m_pend[n][i] || m_rose[n][i]) && !(atendido && (pf == i % p));
      if (nb && !m_pend[n][i]) m_nuevo[n] = 1;
      m_pend[n][i] = nb;
    end
    for (int i = 0; i < 3*p; i++) begin
      m_rose[n][i] = 0;
      if (m_d2[n][i] != m_filt[n][i]) begin
        m_run[n][i]++;
        if (m_run[n][i] == nd[n]) begin
          m_filt[n][i] = !m_filt[n][i];
          m_run[n][i]  = 0;
          m_rose[n][i] = m_filt[n][i];
        end
      end else begin
        m_run[n][i] = 0;
      end
      m_d2[n][i] = m_d1[n][i];
      m_d1[n][i] = raw_bit(n, i);
    end
  endtask

  function automatic logic [31:0] pack(input int n, input int set);
    logic [31:0] v = '0;
    for (int j = 0; j < np[n]; j++) v[j] = m_pend[n][set*np[n]+j];
    return v;
  endfunction

  task automatic chk_inst(input int n, input logic [31:0] gc, input logic [31:0] gs,
                          input logic [31:0] gb, input logic [31:0] gk, input logic gn);
    chk({names[n], ".pend_cab"},   gc, pack(n, 0));
    chk({names[n], ".pend_sube"},  gs, pack(n, 1));
    chk({names[n], ".pend_baja"},  gb, pack(n, 2));
    chk({names[n], ".boton_pres"}, gk, m_code[n]);
    chk({names[n], ".nuevo"},      {31'b0, gn}, {31'b0, m_nuevo[n]});
  endtask

  task automatic step(input int k);
    for (int s = 0; s < k; s++) begin
      @(posedge clk);
      for (int n = 0; n < 3; n++) begin
        if (!rst_n) model_reset(n);
        else        model_step(n);
      end
      #1;
      chk_inst(0, a_cab, a_sube, a_baja, a_code, a_nuevo);
      chk_inst(1, b_cab, b_sube, b_baja, b_code, b_nuevo);
      chk_inst(2, c_cab, c_sube, c_baja, c_code, c_nuevo);
    end
  endtask

  initial begin
    rst_n = 1'b0; cab = '0; sube = '0; baja = '0; atendido = 1'b0; piso = '0;

    for (int k = 0; k < 5; k++) begin
      cab = 8'($urandom); sube = 8'($urandom); baja = 8'($urandom);
      atendido = 1'($urandom); piso = 3'($urandom);
      step(1);
    end
    chk("rst.pend_cab", a_cab, 0);
    chk("rst.code", a_code, 0);
    chk("rst.nuevo", a_nuevo, 0);

    cab = '0; sube = '0; baja = '0; atendido = 1'b0; piso = '0;
    rst_n = 1'b1;
    step(20);
    chk("idle.pend_cab", a_cab, 0);
    chk("idle.code", b_code, 0);

    cab[2] = 1'b1;
    step(6);
    chk("lat.early_code", a_code, 0);
    step(1);
    chk("lat.pend_cab", a_cab, 4'b0100);
    chk("lat.code", a_code, 3);
    chk("lat.nuevo", a_nuevo, 1);
    step(1);
    chk("lat.nuevo_off", a_nuevo, 0);
    cab[2] = 1'b0;
    step(6);
    chk("rel.code_held", a_code, 3);
    step(1);
    chk("rel.code", a_code, 0);
    chk("rel.pend_cab", a_cab, 4'b0100);

    sube[0] = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) sube[0] = 1'b0;
      step(1);
      chk("glitch.nuevo", a_nuevo, 0);
    end
    chk("glitch.pend_sube", a_sube, 0);

    baja[1] = 1'b1; sube[2] = 1'b1;
    step(7);
    chk("prio.b2", a_code, 6);
    cab[3] = 1'b1;
    step(7);
    chk("prio.cab4", a_code, 4);
    cab[3] = 1'b0;
    step(7);
    chk("prio.back", a_code, 6);
    chk("prio.pend_sube", a_sube, 4'b0100);
    chk("prio.pend_baja", a_baja, 4'b0010);
    baja = '0; sube = '0;
    step(7);

    cab[1] = 1'b1; sube[1] = 1'b1; baja[1] = 1'b1;
    step(7);
    cab = '0; sube = '0; baja = '0;
    step(7);
    chk("clr.pre_cab", a_cab, 4'b1110);
    chk("clr.pre_sube", a_sube, 4'b0110);
    cab[1] = 1'b1;
    step(6);
    atendido = 1'b1; piso = 3'd1;
    step(1);
    atendido = 1'b0;
    chk("clr.cab", a_cab, 4'b1100);
    chk("clr.sube", a_sube, 4'b0100);
    chk("clr.baja", a_baja, 4'b0000);
    chk("clr.nuevo", a_nuevo, 0);
    step(8);
    chk("clr.held", a_cab, 4'b1100);
    cab = '0;
    step(7);

    atendido = 1'b1; piso = 3'd5;
    step(1);
    atendido = 1'b0; piso = '0;
    chk("oor.c_cab", c_cab, 5'b01100);
    chk("oor.c_sube", c_sube, 5'b00101);

    sube[6] = 1'b1;
    step(4);
    chk("p8.up7", b_code, 21);
    sube[6] = 1'b0; baja[7] = 1'b1;
    step(4);
    chk("p8.dn8", b_code, 22);
    baja[7] = 1'b0; sube[7] = 1'b1; baja[0] = 1'b1;
    step(6);
    chk("p8.ign_code", b_code, 0);
    chk("p8.ign_up8", b_sube[7], 0);
    chk("p8.ign_dn1", b_baja[0], 0);
    chk("p8.up7_pend", b_sube[6], 1);
    chk("p8.dn8_pend", b_baja[7], 1);
    sube = '0; baja = '0;
    step(4);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        cab  = 8'($urandom & $urandom);
        sube = 8'($urandom & $urandom);
        baja = 8'($urandom & $urandom);
      end
      atendido = ($urandom_range(0, 7) == 0);
      piso     = 3'($urandom);
      rst_n    = ($urandom_range(0, 299) != 0);
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
